vend_controller: RTL and testbench
==================================

VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- PRICE_A, 3, price of product A in credit units (1 unit = 5-coin); legal range 1..15.
- PRICE_B, 4, price of product B in credit units; legal range 1..15.
- TIMEOUT, 255, idle cycles in COLLECT before automatic refund; legal range 1..255.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, reset; asynchronous and active-high.
- coin, in, 2, coin per cycle: 01 = 1 unit, 10 = 2 units, 00/11 = no coin.
- sel, in, 2, product select: 01 = A, 10 = B, 00/11 = none.
- cancel, in, 1, refund request.
- vend_req, out, 1, dispense request to the motor.
- vend_id, out, 1, product being dispensed: 0 = A, 1 = B.
- vend_ack, in, 1, dispense done.
- chg_req, out, 1, change request, one unit per ack.
- chg_ack, in, 1, one change unit returned.
- credit, out, 4, current credit in units.
- busy, out, 1, high in VEND and CHANGE.
- coin_reject, out, 1, one-cycle pulse: coin not accepted.
- sel_short, out, 1, one-cycle pulse: selection with insufficient credit.

Function
REQ-003 The FSM SHALL have states IDLE, COLLECT, VEND and CHANGE; all outputs are registered.

REQ-004 IDLE: a valid coin SHALL add its value to credit and move to COLLECT; sel and cancel SHALL be ignored.

REQ-005 COLLECT coin handling:
- A valid coin SHALL add to credit.
- A coin that would push credit above 15 SHALL be rejected: coin_reject pulses the next cycle and credit is unchanged.

REQ-006 COLLECT select handling:
- If sel is valid and credit >= price, the FSM SHALL go to VEND; credit decreases by price on that edge and vend_id is latched.
- If credit < price, sel_short SHALL pulse and the state is unchanged.

REQ-007 COLLECT cancel SHALL move the FSM to CHANGE with credit unchanged.

REQ-008 Same-cycle priority in COLLECT SHALL be cancel > sel > coin:
- A coin arriving in the same cycle as an accepted cancel or successful sel is rejected (coin_reject pulse).
- A coin arriving with a short sel is accepted.

REQ-009 Timeout counter:
- Cleared on entry to COLLECT and on every accepted coin or any valid sel.
- When it reaches TIMEOUT, the FSM SHALL enter CHANGE.

REQ-010 VEND:
- vend_req SHALL be high from the first cycle in VEND until the cycle vend_ack is sampled high.
- On that edge the FSM goes to CHANGE if credit > 0, otherwise to IDLE.

REQ-011 CHANGE:
- chg_req SHALL be high while credit > 0.
- Each cycle with chg_ack high SHALL decrement credit by 1.
- When credit reaches 0, chg_req drops in the same cycle and the FSM returns to IDLE.

REQ-012 In VEND and CHANGE, every valid coin SHALL be rejected, and sel and cancel SHALL be ignored.

REQ-013 vend_ack outside VEND and chg_ack while chg_req is low SHALL be ignored.

REQ-014 Credit SHALL never wrap or go below 0.

REQ-015 The design SHALL contain no latches and have no combinational input-to-output path.

Reset
REQ-016 While rst is high:
- state = IDLE;
- credit = 0;
- timeout counter = 0;
- vend_req, vend_id, chg_req, busy, coin_reject and sel_short = 0.

REQ-017 Reset asserted mid-VEND or mid-CHANGE SHALL drop vend_req or chg_req asynchronously and discard the credit.

REQ-018 The first state update after reset release SHALL occur on the first rising clk edge with rst low.

Verification
REQ-019 Exact pay: coins 01, 10 then sel=01 -> VEND with credit 0, vend_id=0; vend_req held until vend_ack; then IDLE.

REQ-020 Overpay: coins 10, 10, 10 then sel=10 -> credit 6 becomes 2, vend_id=1; after vend_ack, chg_req stays high for exactly 2 chg_ack pulses; then IDLE with credit 0.

REQ-021 Short and cancel: coin 01, sel=10 -> sel_short pulse, credit 1; then cancel -> CHANGE, 1 chg_ack, IDLE.

REQ-022 Saturation and priority:
- Credit 14 plus coin 10 -> coin_reject, credit stays 14.
- cancel and coin 01 in the same cycle -> coin_reject, refund of 14.

REQ-023 Timeout: coin 01 then 255 idle cycles -> CHANGE entered on cycle 255; credit 1 refunded.

REQ-024 Reset: rst asserted while vend_req is high -> vend_req and credit 0 without a clock edge; after release, coin 10 is accepted normally.

Source files
------------

// File: rtl/vend_controller_if.sv
// Handshake bundle between the vending controller and its coin, keypad, motor and change-return peripherals.
interface vend_controller_if;
  logic [1:0] coin;
  logic [1:0] sel;
  logic       cancel;
  logic       vend_req;
  logic       vend_id;
  logic       vend_ack;
  logic       chg_req;
  logic       chg_ack;
  logic [3:0] credit;
  logic       busy;
  logic       coin_reject;
  logic       sel_short;

  modport slave (
    input  coin, sel, cancel, vend_ack, chg_ack,
    output vend_req, vend_id, chg_req, credit, busy, coin_reject, sel_short
  );

  modport master (
    output coin, sel, cancel, vend_ack, chg_ack,
    input  vend_req, vend_id, chg_req, credit, busy, coin_reject, sel_short
  );
endinterface

// File: rtl/vend_controller.sv
// Two-product vending controller: collects coins, vends, returns change one unit per ack, refunds on cancel or idle timeout.
module vend_controller #(
  parameter int unsigned PRICE_A = 3,
  parameter int unsigned PRICE_B = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  vend_controller_if.slave bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_VEND    = 2'd2;
  localparam logic [1:0] S_CHANGE  = 2'd3;

  localparam logic [3:0] PA       = 4'(PRICE_A);
  localparam logic [3:0] PB       = 4'(PRICE_B);
  localparam logic [7:0] TMR_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] credit_q, credit_d;
  logic [7:0] tmr_q, tmr_d;
  logic       vend_id_q, vend_id_d;
  logic       coin_reject_q, coin_reject_d;
  logic       sel_short_q, sel_short_d;
  logic       vend_req_q, chg_req_q, busy_q;

  logic [4:0] coin_val;
  logic [4:0] coin_sum;
  logic       coin_vld, sel_vld, coin_acc;
  logic [3:0] price;

  always_comb begin
    coin_val = (bus.coin == 2'b01) ? 5'd1 : (bus.coin == 2'b10) ? 5'd2 : 5'd0;
    coin_vld = (coin_val != 5'd0);
    coin_sum = {1'b0, credit_q} + coin_val;
    sel_vld  = (bus.sel == 2'b01) || (bus.sel == 2'b10);
    price    = (bus.sel == 2'b10) ? PB : PA;
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    tmr_d         = tmr_q;
    vend_id_d     = vend_id_q;
    coin_reject_d = 1'b0;
    sel_short_d   = 1'b0;
    coin_acc      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (coin_vld) begin
          credit_d = coin_sum[3:0];
          state_d  = S_COLLECT;
          tmr_d    = '0;
        end
      end

      S_COLLECT: begin
        // Priority cancel > successful sel > coin; a short sel still lets the coin through.
        if (bus.cancel) begin
          state_d       = S_CHANGE;
          coin_reject_d = coin_vld;
          tmr_d         = '0;
        end else if (sel_vld && (credit_q >= price)) begin
          state_d       = S_VEND;
          credit_d      = credit_q - price;
          vend_id_d     = (bus.sel == 2'b10);
          coin_reject_d = coin_vld;
          tmr_d         = '0;
        end else begin
          sel_short_d   = sel_vld;
          coin_acc      = coin_vld && !coin_sum[4];
          coin_reject_d = coin_vld && coin_sum[4];
          if (coin_acc)
            credit_d = coin_sum[3:0];
          if (coin_acc || sel_vld) begin
            tmr_d = '0;
          end else if (tmr_q == TMR_LAST) begin
            state_d = S_CHANGE;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 8'd1;
          end
        end
      end

      S_VEND: begin
        coin_reject_d = coin_vld;
        if (bus.vend_ack)
          state_d = (credit_q != 4'd0) ? S_CHANGE : S_IDLE;
      end

      S_CHANGE: begin
        coin_reject_d = coin_vld;
        if (chg_req_q && bus.chg_ack)
          credit_d = credit_q - 4'd1;
        if (credit_d == 4'd0)
          state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      tmr_q         <= '0;
      vend_id_q     <= 1'b0;
      coin_reject_q <= 1'b0;
      sel_short_q   <= 1'b0;
      vend_req_q    <= 1'b0;
      chg_req_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      tmr_q         <= tmr_d;
      vend_id_q     <= vend_id_d;
      coin_reject_q <= coin_reject_d;
      sel_short_q   <= sel_short_d;
      // Request/busy flags registered from next-state so they track the state without decode glitches.
      vend_req_q    <= (state_d == S_VEND);
      chg_req_q     <= (state_d == S_CHANGE) && (credit_d != 4'd0);
      busy_q        <= (state_d == S_VEND) || (state_d == S_CHANGE);
    end
  end

  assign bus.vend_req    = vend_req_q;
  assign bus.vend_id     = vend_id_q;
  assign bus.chg_req     = chg_req_q;
  assign bus.credit      = credit_q;
  assign bus.busy        = busy_q;
  assign bus.coin_reject = coin_reject_q;
  assign bus.sel_short   = sel_short_q;

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed purchase/refund scenarios plus random traffic against a behavioural model.
module tb_vend_controller;

  localparam int PA = 3;
  localparam int PB = 4;
  localparam int TO = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vend_controller_if bus ();

  vend_controller #(.PRICE_A(PA), .PRICE_B(PB), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  typedef enum int {M_IDLE, M_COLLECT, M_VEND, M_CHANGE} mphase_t;
  mphase_t ph;
  int      cr, idle_cnt;
  bit      m_vreq, m_vid, m_creq, m_busy, m_crej, m_sshort;

  function automatic int coin_units(input logic [1:0] c);
    return (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : 0;
  endfunction

  function automatic int price_of(input logic [1:0] s);
    return (s == 2'b01) ? PA : (s == 2'b10) ? PB : 0;
  endfunction

  task automatic model_reset();
    ph = M_IDLE; cr = 0; idle_cnt = 0;
    m_vreq = 0; m_vid = 0; m_creq = 0; m_busy = 0; m_crej = 0; m_sshort = 0;
  endtask

  task automatic model_step(input logic [1:0] c, input logic [1:0] s, input logic can,
                            input logic va, input logic ca);
    int cu = coin_units(c);
    int p  = price_of(s);
    bit active;
    m_crej = 0;
    m_sshort = 0;
    case (ph)
      M_IDLE: if (cu > 0) begin cr += cu; ph = M_COLLECT; idle_cnt = 0; end
      M_COLLECT: begin
        if (can) begin
          m_crej = (cu > 0); ph = M_CHANGE;
        end else if (p > 0 && cr >= p) begin
          cr -= p; m_vid = (s == 2'b10); ph = M_VEND; m_crej = (cu > 0);
        end else begin
          active = (p > 0);
          m_sshort = (p > 0);
          if (cu > 0) begin
            if (cr + cu <= 15) begin cr += cu; active = 1; end
            else m_crej = 1;
          end
          if (active) idle_cnt = 0;
          else begin
            idle_cnt++;
            if (idle_cnt == TO) begin ph = M_CHANGE; idle_cnt = 0; end
          end
        end
      end
      M_VEND: begin
        m_crej = (cu > 0);
        if (va) ph = (cr > 0) ? M_CHANGE : M_IDLE;
      end
      M_CHANGE: begin
        m_crej = (cu > 0);
        if (m_creq && ca) cr--;
        if (cr == 0) ph = M_IDLE;
      end
      default: ph = M_IDLE;
    endcase
    m_vreq = (ph == M_VEND);
    m_creq = (ph == M_CHANGE) && (cr > 0);
    m_busy = (ph == M_VEND) || (ph == M_CHANGE);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("credit",      32'(bus.credit),      32'(cr));
    chk("vend_req",    32'(bus.vend_req),    32'(m_vreq));
    chk("vend_id",     32'(bus.vend_id),     32'(m_vid));
    chk("chg_req",     32'(bus.chg_req),     32'(m_creq));
    chk("busy",        32'(bus.busy),        32'(m_busy));
    chk("coin_reject", 32'(bus.coin_reject), 32'(m_crej));
    chk("sel_short",   32'(bus.sel_short),   32'(m_sshort));
  endtask

  task automatic drive(input logic [1:0] c, input logic [1:0] s, input logic can,
                       input logic va, input logic ca);
    bus.coin = c; bus.sel = s; bus.cancel = can; bus.vend_ack = va; bus.chg_ack = ca;
  endtask

  task automatic step(input logic [1:0] c, input logic [1:0] s, input logic can,
                      input logic va, input logic ca);
    drive(c, s, can, va, ca);
    @(posedge clk);
    model_step(c, s, can, va, ca);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    chk("rst_credit", 32'(bus.credit), 0);
    @(negedge clk) rst = 1'b0;

    // Exact pay for A
    step(2'b01, 2'b00, 0, 0, 0);
    step(2'b10, 2'b00, 0, 0, 0);
    chk("exact_credit3", 32'(bus.credit), 3);
    step(2'b00, 2'b01, 0, 0, 0);
    chk("exact_vreq", 32'(bus.vend_req), 1);
    chk("exact_credit0", 32'(bus.credit), 0);
    chk("exact_vid", 32'(bus.vend_id), 0);
    idle(3);
    chk("exact_vreq_hold", 32'(bus.vend_req), 1);
    step(2'b00, 2'b00, 0, 1, 0);
    chk("exact_idle", 32'(bus.busy), 0);
    step(2'b00, 2'b00, 0, 1, 1);

    // Overpay for B with two units of change
    step(2'b10, 2'b00, 0, 0, 0);
    step(2'b10, 2'b00, 0, 0, 0);
    step(2'b10, 2'b00, 0, 0, 0);
    chk("over_credit6", 32'(bus.credit), 6);
    step(2'b00, 2'b10, 0, 0, 0);
    chk("over_credit2", 32'(bus.credit), 2);
    chk("over_vid", 32'(bus.vend_id), 1);
    step(2'b00, 2'b00, 0, 1, 0);
    chk("over_chg_req", 32'(bus.chg_req), 1);
    step(2'b00, 2'b00, 0, 0, 1);
    chk("over_chg_mid", 32'(bus.chg_req), 1);
    step(2'b01, 2'b00, 0, 0, 1);
    chk("over_chg_done", 32'(bus.chg_req), 0);
    chk("over_credit0", 32'(bus.credit), 0);
    chk("over_idle", 32'(bus.busy), 0);

    // Short selection then cancel
    step(2'b01, 2'b00, 0, 0, 0);
    step(2'b00, 2'b10, 0, 0, 0);
    chk("short_pulse", 32'(bus.sel_short), 1);
    chk("short_credit", 32'(bus.credit), 1);
    idle(1);
    step(2'b00, 2'b00, 1, 0, 0);
    chk("cancel_chg", 32'(bus.chg_req), 1);
    step(2'b00, 2'b00, 0, 0, 1);
    chk("cancel_idle", 32'(bus.busy), 0);

    // Saturation and cancel-over-coin priority
    for (int i = 0; i < 7; i++) step(2'b10, 2'b00, 0, 0, 0);
    chk("sat_credit14", 32'(bus.credit), 14);
    step(2'b10, 2'b00, 0, 0, 0);
    chk("sat_reject", 32'(bus.coin_reject), 1);
    chk("sat_credit", 32'(bus.credit), 14);
    step(2'b01, 2'b00, 1, 0, 0);
    chk("prio_reject", 32'(bus.coin_reject), 1);
    chk("prio_refund", 32'(bus.credit), 14);
    for (int i = 0; i < 14; i++) step(2'b00, 2'b00, 0, 0, 1);
    chk("prio_done", 32'(bus.busy), 0);

    // Idle timeout refund
    step(2'b01, 2'b00, 0, 0, 0);
    idle(TO - 1);
    chk("to_before", 32'(bus.busy), 0);
    idle(1);
    chk("to_enter", 32'(bus.chg_req), 1);
    chk("to_credit", 32'(bus.credit), 1);
    step(2'b00, 2'b00, 0, 0, 1);
    chk("to_idle", 32'(bus.busy), 0);

    // Asynchronous reset while vending
    step(2'b10, 2'b00, 0, 0, 0);
    step(2'b10, 2'b00, 0, 0, 0);
    step(2'b00, 2'b10, 0, 0, 0);
    chk("ar_vreq", 32'(bus.vend_req), 1);
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("ar_vreq_drop", 32'(bus.vend_req), 0);
    chk("ar_credit", 32'(bus.credit), 0);
    chk("ar_busy", 32'(bus.busy), 0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step(2'b10, 2'b00, 0, 0, 0);
    chk("ar_coin", 32'(bus.credit), 2);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] c, s;
      logic can, va, ca;
      c   = 2'($urandom_range(0, 3));
      s   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      can = ($urandom_range(0, 15) == 0);
      va  = ($urandom_range(0, 3) == 0);
      ca  = 1'($urandom_range(0, 1));
      step(c, s, can, va, ca);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
